// File: rtl/shift_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_scheduler_if
// Description : Two-requester shift request bus plus result handshake for
//               shift_scheduler. The slave side is the scheduler; the master
//               side is whoever issues requests and consumes results.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_scheduler_if #(
  parameter int N = 32
);
  // Requester A
  logic         a_valid;
  logic         a_ready;
  logic [N-1:0] a_in;
  logic [4:0]   a_shamt;
  logic [1:0]   a_op;

  // Requester B
  logic         b_valid;
  logic         b_ready;
  logic [N-1:0] b_in;
  logic [4:0]   b_shamt;
  logic [1:0]   b_op;

  // Result channel
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_id;

  // Status
  logic         busy;

  modport slave (
    input  a_valid, a_in, a_shamt, a_op,
    input  b_valid, b_in, b_shamt, b_op,
    input  out_ready,
    output a_ready, b_ready,
    output out_valid, out_data, out_id,
    output busy
  );

  modport master (
    output a_valid, a_in, a_shamt, a_op,
    output b_valid, b_in, b_shamt, b_op,
    output out_ready,
    input  a_ready, b_ready,
    input  out_valid, out_data, out_id,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/shift_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : shift_scheduler
// Description : Round-robin arbiter in front of a multi-cycle barrel shifter.
//               One accepted request is shifted over five fixed stages (one
//               per shamt bit, 1/2/4/8/16 positions) and the result is held
//               until the consumer takes it. Latency is constant at five
//               clock edges from accept to out_valid regardless of shamt.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_scheduler #(
  parameter int N = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  shift_scheduler_if.slave  bus
);

  localparam int              SHAMT_W    = 5;
  localparam int              CNT_W      = 3;
  localparam logic [CNT_W-1:0] LAST_STAGE = 3'd4;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ptr;       // 0 = A has priority on a tie, 1 = B
  logic [N-1:0]        r_acc;
  logic [SHAMT_W-1:0]  r_shamt;
  logic [1:0]          r_op;
  logic                r_id;
  logic                r_sign;      // MSB of the captured operand, SRA fill
  logic                r_out_valid;
  logic [N-1:0]        r_out_data;
  logic                r_out_id;

  logic                w_idle;
  logic                w_grant_a;
  logic                w_grant_b;
  logic                w_accept_a;
  logic                w_accept_b;
  logic [N-1:0]        w_stage_shifted;
  logic [N-1:0]        w_stage_val;

  // One shift stage: move val by 2^k positions according to op. Op 11 falls
  // into the default branch and therefore behaves as SLL.
  function automatic logic [N-1:0] stage_shift(
    input logic [N-1:0]     val,
    input logic [CNT_W-1:0] k,
    input logic [1:0]       op,
    input logic             sign
  );
    logic [SHAMT_W:0] amt;
    logic [N-1:0]     fill;
    amt  = {{SHAMT_W{1'b0}}, 1'b1} << k;
    // Ones in the vacated upper positions when the original operand was negative
    fill = sign ? ~({N{1'b1}} >> amt) : {N{1'b0}};
    case (op)
      OP_SRL:  stage_shift = val >> amt;
      OP_SRA:  stage_shift = (val >> amt) | fill;
      default: stage_shift = val << amt;
    endcase
  endfunction

  // Arbitration: a lone requester always wins; on a tie the pointer decides.
  // Grants are combinational so ready follows valid in the same cycle.
  always_comb begin
    w_idle     = (r_state == IDLE);
    w_grant_a  = bus.a_valid & (~bus.b_valid | ~r_ptr);
    w_grant_b  = bus.b_valid & (~bus.a_valid |  r_ptr);
    w_accept_a = w_idle & w_grant_a;
    w_accept_b = w_idle & w_grant_b;
  end

  // Datapath for the stage selected by the counter; a clear shamt bit holds
  // the accumulator so every shamt costs the same five edges.
  always_comb begin
    w_stage_shifted = stage_shift(r_acc, r_cnt, r_op, r_sign);
    w_stage_val     = r_shamt[r_cnt] ? w_stage_shifted : r_acc;
  end

  // Control FSM with captured request, accumulator and registered result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ptr       <= 1'b0;
      r_acc       <= '0;
      r_shamt     <= '0;
      r_op        <= '0;
      r_id        <= 1'b0;
      r_sign      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          // Capture the granted request; inputs are ignored from here on
          if (w_accept_a) begin
            r_acc   <= bus.a_in;
            r_shamt <= bus.a_shamt;
            r_op    <= bus.a_op;
            r_id    <= 1'b0;
            r_sign  <= bus.a_in[N-1];
            r_cnt   <= '0;
            r_state <= SHIFT;
          end else if (w_accept_b) begin
            r_acc   <= bus.b_in;
            r_shamt <= bus.b_shamt;
            r_op    <= bus.b_op;
            r_id    <= 1'b1;
            r_sign  <= bus.b_in[N-1];
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end

        SHIFT: begin
          r_acc <= w_stage_val;
          r_cnt <= r_cnt + 3'd1;
          // The last stage result goes straight to the output register so
          // out_valid rises on this same edge
          if (r_cnt == LAST_STAGE) begin
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_out_data  <= w_stage_val;
            r_out_id    <= r_id;
          end
        end

        DONE: begin
          // Result held until taken; then hand priority to the other side
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= 1'b0;
            r_ptr       <= ~r_id;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.a_ready   = w_accept_a;
  assign bus.b_ready   = w_accept_b;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_id    = r_out_id;
  assign bus.busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_shift_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_scheduler
// Description : Directed self-checking bench for shift_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_scheduler;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  shift_scheduler_if #(.N(32)) bus ();

  shift_scheduler #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything stalls
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.a_valid = 1'b0; bus.a_in = '0; bus.a_shamt = '0; bus.a_op = '0;
    bus.b_valid = 1'b0; bus.b_in = '0; bus.b_shamt = '0; bus.b_op = '0;
  endtask

  // Drive one request from the idle state and checks accept, fixed latency,
  // result and return to idle. Inputs are scrambled after accept.
  task automatic do_op(input string tag, input bit id, input logic [31:0] val,
                       input logic [4:0] sh, input logic [1:0] op, input logic [31:0] exp);
    bus.out_ready = 1'b1;
    if (!id) begin
      bus.a_valid = 1'b1; bus.a_in = val; bus.a_shamt = sh; bus.a_op = op;
    end else begin
      bus.b_valid = 1'b1; bus.b_in = val; bus.b_shamt = sh; bus.b_op = op;
    end
    #1;
    check_eq({tag, "/a_ready"}, 32'(bus.a_ready), 32'(!id));
    check_eq({tag, "/b_ready"}, 32'(bus.b_ready), 32'(id));
    @(posedge clk); #1;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    bus.a_in = ~val; bus.b_in = ~val; bus.a_shamt = ~sh; bus.b_shamt = ~sh;
    bus.a_op = ~op; bus.b_op = ~op;
    check_eq({tag, "/busy"}, 32'(bus.busy), 32'd1);
    for (int i = 1; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq({tag, "/early_valid"}, 32'(bus.out_valid), 32'd0);
      check_eq({tag, "/idle_data"}, bus.out_data, 32'd0);
    end
    @(posedge clk); #1;
    check_eq({tag, "/valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, "/data"}, bus.out_data, exp);
    check_eq({tag, "/id"}, 32'(bus.out_id), 32'(id));
    @(posedge clk); #1;
    check_eq({tag, "/valid_drop"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, "/busy_drop"}, 32'(bus.busy), 32'd0);
    clear_inputs();
  endtask

  initial begin
    logic [31:0] exp_id;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.out_ready = 1'b1;
    clear_inputs();

    // Reset state
    #2;
    check_eq("rst/out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst/out_data",  bus.out_data, 32'd0);
    check_eq("rst/out_id",    32'(bus.out_id), 32'd0);
    check_eq("rst/busy",      32'(bus.busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Directed operations
    do_op("sll31",    1'b0, 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000);
    do_op("sra4",     1'b1, 32'h8000_0000, 5'd4,  2'b10, 32'hF800_0000);
    do_op("srl4",     1'b1, 32'h8000_0000, 5'd4,  2'b01, 32'h0800_0000);
    do_op("op11_sh0", 1'b0, 32'hDEAD_BEEF, 5'd0,  2'b11, 32'hDEAD_BEEF);
    do_op("sll5",     1'b0, 32'h1234_5678, 5'd5,  2'b00, 32'h468A_CF00);
    do_op("sra_pos",  1'b1, 32'h7000_0000, 5'd3,  2'b10, 32'h0E00_0000);
    do_op("sra31",    1'b0, 32'hF000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF);
    do_op("srl28",    1'b1, 32'hF000_0000, 5'd28, 2'b01, 32'h0000_000F);
    do_op("op11_sh9", 1'b1, 32'h0000_00FF, 5'd9,  2'b11, 32'h0001_FE00);

    // Back-pressure in DONE
    bus.out_ready = 1'b0;
    bus.a_valid = 1'b1; bus.a_in = 32'h1234_5678; bus.a_shamt = 5'd8; bus.a_op = 2'b01;
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("stall/valid", 32'(bus.out_valid), 32'd1);
    check_eq("stall/data",  bus.out_data, 32'h0012_3456);
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("stall/hold_valid", 32'(bus.out_valid), 32'd1);
      check_eq("stall/hold_data",  bus.out_data, 32'h0012_3456);
      check_eq("stall/hold_id",    32'(bus.out_id), 32'd0);
      check_eq("stall/a_ready",    32'(bus.a_ready), 32'd0);
      check_eq("stall/b_ready",    32'(bus.b_ready), 32'd0);
      check_eq("stall/busy",       32'(bus.busy), 32'd1);
    end
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("stall/release_busy",  32'(bus.busy), 32'd0);
    check_eq("stall/release_valid", 32'(bus.out_valid), 32'd0);
    // A was just served, so B now wins a tie
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    #1;
    check_eq("ptr/a_ready", 32'(bus.a_ready), 32'd0);
    check_eq("ptr/b_ready", 32'(bus.b_ready), 32'd1);
    clear_inputs();

    // Both requesters held high from reset: A, B, A, B
    @(negedge clk);
    rst_n = 1'b0;
    bus.a_valid = 1'b1; bus.a_in = 32'h0000_0001; bus.a_shamt = 5'd1; bus.a_op = 2'b00;
    bus.b_valid = 1'b1; bus.b_in = 32'h0000_0100; bus.b_shamt = 5'd4; bus.b_op = 2'b01;
    bus.out_ready = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_id = 32'(k % 2);
      check_eq("rr/a_ready", 32'(bus.a_ready), 32'(exp_id == 0));
      check_eq("rr/b_ready", 32'(bus.b_ready), 32'(exp_id == 1));
      @(posedge clk); #1;
      check_eq("rr/busy", 32'(bus.busy), 32'd1);
      for (int i = 1; i < 5; i++) begin
        check_eq("rr/no_ready", 32'(bus.a_ready | bus.b_ready), 32'd0);
        @(posedge clk); #1;
        check_eq("rr/early_valid", 32'(bus.out_valid), 32'd0);
      end
      @(posedge clk); #1;
      check_eq("rr/valid", 32'(bus.out_valid), 32'd1);
      check_eq("rr/id",    32'(bus.out_id), exp_id);
      check_eq("rr/data",  bus.out_data, (exp_id == 0) ? 32'h0000_0002 : 32'h0000_0010);
      @(posedge clk); #1;
      check_eq("rr/idle", 32'(bus.busy), 32'd0);
    end
    clear_inputs();

    // Reset during SHIFT at stage 2
    bus.a_valid = 1'b1; bus.a_in = 32'h0000_0001; bus.a_shamt = 5'd31; bus.a_op = 2'b00;
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_shift/out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_shift/out_data",  bus.out_data, 32'd0);
    check_eq("rst_shift/out_id",    32'(bus.out_id), 32'd0);
    check_eq("rst_shift/busy",      32'(bus.busy), 32'd0);
    @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      check_eq("rst_shift/no_result", 32'(bus.out_valid), 32'd0);
    end
    do_op("after_rst", 1'b1, 32'h8000_0000, 5'd4, 2'b10, 32'hF800_0000);

    // Reset while holding a result in DONE
    bus.out_ready = 1'b0;
    bus.b_valid = 1'b1; bus.b_in = 32'hABCD_0000; bus.b_shamt = 5'd16; bus.b_op = 2'b01;
    @(posedge clk); #1;
    bus.b_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("rst_done/pre_data", bus.out_data, 32'h0000_ABCD);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rst_done/out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_done/out_data",  bus.out_data, 32'd0);
    check_eq("rst_done/busy",      32'(bus.busy), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_eq("rst_done/no_result", 32'(bus.out_valid), 32'd0);
    end
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
